// File: rtl/alu_vector_sequencer_if.sv
// Signal bundle between the vector sequencer, the ALU under exercise and the
// observing logic (start/pause control, operand drive, result capture).
interface alu_vector_sequencer_if;
   logic       start;
   logic       pause;
   logic [1:0] A;
   logic [1:0] B;
   logic [1:0] sel;
   logic [3:0] Y;
   logic [3:0] y_cap;
   logic       valid;
   logic       busy;
   logic       done;
   logic [6:0] count;
   logic [7:0] checksum;

   modport master (
      input  start, pause, Y,
      output A, B, sel, y_cap, valid, busy, done, count, checksum
   );

   modport slave (
      output start, pause, Y,
      input  A, B, sel, y_cap, valid, busy, done, count, checksum
   );
endinterface

// File: rtl/alu_vector_sequencer.sv
// Sweeps all 64 {A,B,sel} vectors into a 2-bit ALU, holds each for HOLD cycles,
// captures Y at the end of each hold and accumulates a count and 8-bit checksum.
module alu_vector_sequencer #(
   parameter int unsigned HOLD = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   alu_vector_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
   localparam logic [5:0] IDX_LAST  = 6'd63;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [5:0] r_idx;
   logic [5:0] w_idx_nxt;
   logic [7:0] r_hold;
   logic [7:0] w_hold_nxt;
   logic [3:0] r_y_cap;
   logic [3:0] w_y_cap_nxt;
   logic       r_valid;
   logic       w_valid_nxt;
   logic       r_busy;
   logic       w_busy_nxt;
   logic       r_done;
   logic       w_done_nxt;
   logic [6:0] r_count;
   logic [6:0] w_count_nxt;
   logic [7:0] r_checksum;
   logic [7:0] w_checksum_nxt;

   function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [3:0] y);
      return sum + {4'b0000, y};
   endfunction

   // Next-state and next-output decode for the sweep FSM.
   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_hold_nxt     = r_hold;
      w_y_cap_nxt    = r_y_cap;
      w_valid_nxt    = 1'b0;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_count_nxt    = r_count;
      w_checksum_nxt = r_checksum;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt    = S_DRIVE;
               w_idx_nxt      = 6'd0;
               w_hold_nxt     = 8'd0;
               w_count_nxt    = 7'd0;
               w_checksum_nxt = 8'd0;
               w_busy_nxt     = 1'b1;
            end else begin
               w_busy_nxt     = 1'b0;
            end
         end

         S_DRIVE: begin
            // A paused cycle leaves every register untouched, including the sample.
            if (bus.pause) begin
               w_hold_nxt = r_hold;
            end else if (r_hold == HOLD_LAST) begin
               w_y_cap_nxt    = bus.Y;
               w_checksum_nxt = csum_add(r_checksum, bus.Y);
               w_count_nxt    = r_count + 7'd1;
               w_valid_nxt    = 1'b1;
               w_hold_nxt     = 8'd0;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = S_DONE;
                  w_idx_nxt   = 6'd0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt   = r_idx + 6'd1;
               end
            end else begin
               w_hold_nxt = r_hold + 8'd1;
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 6'd0;
            w_hold_nxt  = 8'd0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_idx      <= 6'd0;
         r_hold     <= 8'd0;
         r_y_cap    <= 4'd0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_count    <= 7'd0;
         r_checksum <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_hold     <= w_hold_nxt;
         r_y_cap    <= w_y_cap_nxt;
         r_valid    <= w_valid_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_count    <= w_count_nxt;
         r_checksum <= w_checksum_nxt;
      end
   end

   // sel is the fastest-moving field, A the slowest.
   assign bus.A        = r_idx[5:4];
   assign bus.B        = r_idx[3:2];
   assign bus.sel      = r_idx[1:0];
   assign bus.y_cap    = r_y_cap;
   assign bus.valid    = r_valid;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.count    = r_count;
   assign bus.checksum = r_checksum;

endmodule
